// File: rtl/init_done_sequencer.sv
// init_done_sequencer: synchronises POR/init-done flags, qualifies them, then
// releases staged resets. Define INIT_SEQ_LOSS_DETECT_EN to fault on loss in READY.
module init_done_sequencer #(
    parameter int N_CH           = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int N_STAGE        = 3,
    parameter int RELEASE_DLY    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FABRIC_POR_N,
    input  logic [N_CH-1:0]    DONE_IN,
    input  logic [N_CH-1:0]    CH_MASK,
    input  logic               CLR_FAULT,
    output logic [N_CH-1:0]    DONE_SYNC,
    output logic [N_STAGE-1:0] STAGE_RESET_N,
    output logic               SYS_READY,
    output logic               TIMEOUT_ERR,
    output logic [2:0]         STATE
);

    typedef enum logic [2:0] {
        S_WAIT_POR  = 3'd0,
        S_WAIT_DONE = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_READY     = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ST_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RL_LIM = RELEASE_DLY * N_STAGE;
    localparam int RL_W   = (RL_LIM > 1) ? $clog2(RL_LIM) : 1;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES - 1);
    localparam logic [RL_W-1:0] RL_LAST = RL_W'(RL_LIM - 1);

    logic [SYNC_STAGES-1:0][N_CH:0] r_sync;
    logic [N_CH:0]                  w_sync_out;
    logic                           w_por_n;
    logic                           w_all_done;
    logic                           w_to_hit;

    state_t             r_state;
    state_t             w_nxt;
    logic [TO_W-1:0]    r_tcnt;
    logic [TO_W-1:0]    w_tcnt_nxt;
    logic [ST_W-1:0]    r_scnt;
    logic [ST_W-1:0]    w_scnt_nxt;
    logic [RL_W-1:0]    r_rcnt;
    logic [RL_W-1:0]    w_rcnt_nxt;
    logic [N_STAGE-1:0] r_stage_n;
    logic [N_STAGE-1:0] w_stage_nxt;
    logic               r_ready;
    logic               r_terr;

    // POR status rides in the top bit alongside the done flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], {FABRIC_POR_N, DONE_IN}};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_por_n    = w_sync_out[N_CH];
    assign DONE_SYNC  = w_sync_out[N_CH-1:0];
    assign w_all_done = &(DONE_SYNC | ~CH_MASK);

    always_comb begin
        w_nxt    = r_state;
        w_to_hit = (TIMEOUT_CYCLES != 0) && (r_tcnt == TO_LAST);
        case (r_state)
            S_WAIT_POR: begin
                if (w_por_n) w_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_all_done)    w_nxt = S_STABLE;
                else if (w_to_hit) w_nxt = S_FAULT;
            end
            S_STABLE: begin
                if (!w_all_done)            w_nxt = S_WAIT_DONE;
                else if (r_scnt == ST_LAST) w_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_rcnt == RL_LAST) w_nxt = S_READY;
            end
            S_READY: begin
`ifdef INIT_SEQ_LOSS_DETECT_EN
                if (!w_all_done) w_nxt = S_FAULT;
`else
                w_nxt = S_READY;
`endif
            end
            S_FAULT: begin
                if (CLR_FAULT) w_nxt = S_WAIT_POR;
            end
            default: w_nxt = S_WAIT_POR;
        endcase
        if (!w_por_n) w_nxt = S_WAIT_POR;
    end

    // Timeout count survives STABLE excursions; only WAIT_POR clears it
    always_comb begin
        w_tcnt_nxt = r_tcnt;
        if (w_nxt == S_WAIT_POR) begin
            w_tcnt_nxt = '0;
        end else if (r_state == S_WAIT_DONE && w_nxt == S_WAIT_DONE
                     && r_tcnt != '1) begin
            w_tcnt_nxt = r_tcnt + TO_W'(1);
        end

        w_scnt_nxt = '0;
        if (r_state == S_STABLE && w_nxt == S_STABLE && r_scnt != '1) begin
            w_scnt_nxt = r_scnt + ST_W'(1);
        end

        w_rcnt_nxt = '0;
        if (r_state == S_RELEASE && w_nxt == S_RELEASE && r_rcnt != '1) begin
            w_rcnt_nxt = r_rcnt + RL_W'(1);
        end
    end

    // Stage outputs are registered from the values the counters will hold
    always_comb begin
        w_stage_nxt = '0;
        if (w_nxt == S_READY) begin
            w_stage_nxt = '1;
        end else if (w_nxt == S_RELEASE) begin
            for (int k = 0; k < N_STAGE; k++) begin
                w_stage_nxt[k] = (int'(w_rcnt_nxt) >= k * RELEASE_DLY);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_WAIT_POR;
            r_tcnt    <= '0;
            r_scnt    <= '0;
            r_rcnt    <= '0;
            r_stage_n <= '0;
            r_ready   <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_scnt    <= w_scnt_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_stage_n <= w_stage_nxt;
            r_ready   <= (w_nxt == S_READY);
            r_terr    <= (w_nxt == S_FAULT);
        end
    end

    assign STAGE_RESET_N = r_stage_n;
    assign SYS_READY     = r_ready;
    assign TIMEOUT_ERR   = r_terr;
    assign STATE         = r_state;

endmodule

// File: tb/tb_init_done_sequencer.sv
// Bench for init_done_sequencer: timeline expectations queued per scenario,
// popped and compared when the matching cycle is reached.
module tb_init_done_sequencer;

    localparam logic [2:0] WP = 3'd0;
    localparam logic [2:0] WD = 3'd1;
    localparam logic [2:0] ST = 3'd2;
    localparam logic [2:0] RL = 3'd3;
    localparam logic [2:0] RD = 3'd4;
    localparam logic [2:0] FT = 3'd5;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       FABRIC_POR_N = 1'b0;
    logic       CLR_FAULT = 1'b0;
    logic [3:0] DONE_IN = 4'h0;
    logic [3:0] CH_MASK = 4'hF;
    logic [3:0] DONE_SYNC;
    logic [2:0] STAGE_RESET_N;
    logic       SYS_READY;
    logic       TIMEOUT_ERR;
    logic [2:0] STATE;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [2:0] stg;
        logic       rdy;
        logic       terr;
        logic [3:0] ds;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    int   r = 0;

    init_done_sequencer #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .FABRIC_POR_N (FABRIC_POR_N),
        .DONE_IN      (DONE_IN),
        .CH_MASK      (CH_MASK),
        .CLR_FAULT    (CLR_FAULT),
        .DONE_SYNC    (DONE_SYNC),
        .STAGE_RESET_N(STAGE_RESET_N),
        .SYS_READY    (SYS_READY),
        .TIMEOUT_ERR  (TIMEOUT_ERR),
        .STATE        (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input logic por, input logic [3:0] done,
                               input logic [3:0] mask);
        RST = 1'b1;
        FABRIC_POR_N = por;
        DONE_IN = done;
        CH_MASK = mask;
        CLR_FAULT = 1'b0;
        step();
        step();
        RST = 1'b0;
        r = cyc;
    endtask

    function automatic void push(int c, logic [2:0] st, logic [2:0] stg,
                                 logic rdy, logic terr, logic [3:0] ds,
                                 string nm);
        exp_t x;
        x.cyc = c; x.st = st; x.stg = stg;
        x.rdy = rdy; x.terr = terr; x.ds = ds; x.nm = nm;
        sb.push_back(x);
    endfunction

    task automatic test_reset();
        int g = 0;
        exp_t e;
        apply_reset(1'b1, 4'hF, 4'hF);
        push(r + 1, WP, 3'b000, 0, 0, 4'h0, "rst_sync1");
        push(r + 2, WP, 3'b000, 0, 0, 4'hF, "rst_sync2");
        push(r + 3, WD, 3'b000, 0, 0, 4'hF, "rst_wait_done");
        push(r + 4, ST, 3'b000, 0, 0, 4'hF, "rst_stable");
        push(r + 16, RL, 3'b011, 0, 0, 4'hF, "rst_release");
        push(r + 18, WP, 3'b000, 0, 0, 4'h0, "rst_mid_release");
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, cyc, STATE, STAGE_RESET_N, SYS_READY, TIMEOUT_ERR,
                        DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == r + 17) RST = 1'b1;
            if (cyc == r + 18) RST = 1'b0;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_reset: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_normal(input logic [3:0] mask, input logic [3:0] done);
        int g = 0;
        int b;
        exp_t e;
        apply_reset(1'b1, 4'h0, mask);
        b = r + 5;
        push(r + 4, WD, 3'b000, 0, 0, 4'h0, "seq_wait_done");
        push(b + 1, WD, 3'b000, 0, 0, 4'h0, "seq_sync_lat");
        push(b + 2, WD, 3'b000, 0, 0, done, "seq_synced");
        push(b + 3, ST, 3'b000, 0, 0, done, "seq_stable");
        push(b + 10, ST, 3'b000, 0, 0, done, "seq_stable_end");
        push(b + 11, RL, 3'b001, 0, 0, done, "seq_stage0");
        push(b + 14, RL, 3'b001, 0, 0, done, "seq_stage0_hold");
        push(b + 15, RL, 3'b011, 0, 0, done, "seq_stage1");
        push(b + 18, RL, 3'b011, 0, 0, done, "seq_stage1_hold");
        push(b + 19, RL, 3'b111, 0, 0, done, "seq_stage2");
        push(b + 22, RL, 3'b111, 0, 0, done, "seq_pre_ready");
        push(b + 23, RD, 3'b111, 1, 0, done, "seq_ready");
        push(b + 40, RD, 3'b111, 1, 0, done, "seq_ready_hold");
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s mask=%h cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, mask, cyc, STATE, STAGE_RESET_N, SYS_READY,
                        TIMEOUT_ERR, DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == b) DONE_IN = done;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_normal: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout();
        int g = 0;
        exp_t e;
        apply_reset(1'b1, 4'h7, 4'hF);
        push(r + 102, WD, 3'b000, 0, 0, 4'h7, "to_last_wait");
        push(r + 103, FT, 3'b000, 0, 1, 4'h7, "to_fault");
        push(r + 105, FT, 3'b000, 0, 1, 4'h7, "to_fault_hold");
        push(r + 106, WP, 3'b000, 0, 0, 4'h7, "to_clear");
        push(r + 107, WD, 3'b000, 0, 0, 4'h7, "to_restart");
        push(r + 108, WD, 3'b000, 0, 0, 4'h7, "to_clr_ignored");
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, cyc, STATE, STAGE_RESET_N, SYS_READY, TIMEOUT_ERR,
                        DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == r + 105) CLR_FAULT = 1'b1;
            if (cyc == r + 108) CLR_FAULT = 1'b0;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_timeout: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stable_restart();
        int g = 0;
        exp_t e;
        apply_reset(1'b1, 4'hF, 4'hF);
        push(r + 4, ST, 3'b000, 0, 0, 4'hF, "gl_stable");
        push(r + 8, ST, 3'b000, 0, 0, 4'hD, "gl_dip_seen");
        push(r + 9, WD, 3'b000, 0, 0, 4'hF, "gl_back_wait");
        push(r + 10, ST, 3'b000, 0, 0, 4'hF, "gl_restable");
        push(r + 17, ST, 3'b000, 0, 0, 4'hF, "gl_count_restart");
        push(r + 18, RL, 3'b001, 0, 0, 4'hF, "gl_release");
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, cyc, STATE, STAGE_RESET_N, SYS_READY, TIMEOUT_ERR,
                        DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == r + 6) DONE_IN = 4'hD;
            if (cyc == r + 7) DONE_IN = 4'hF;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_stable_restart: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout_hold();
        int g = 0;
        exp_t e;
        apply_reset(1'b1, 4'h7, 4'hF);
        push(r + 42, WD, 3'b000, 0, 0, 4'hF, "th_synced");
        push(r + 43, ST, 3'b000, 0, 0, 4'h7, "th_stable");
        push(r + 44, WD, 3'b000, 0, 0, 4'h7, "th_drop");
        push(r + 104, WD, 3'b000, 0, 0, 4'h7, "th_last_wait");
        push(r + 105, FT, 3'b000, 0, 1, 4'h7, "th_fault");
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, cyc, STATE, STAGE_RESET_N, SYS_READY, TIMEOUT_ERR,
                        DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == r + 40) DONE_IN = 4'hF;
            if (cyc == r + 41) DONE_IN = 4'h7;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_timeout_hold: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_por_loss();
        int g = 0;
        exp_t e;
        apply_reset(1'b1, 4'hF, 4'hF);
        push(r + 12, RL, 3'b001, 0, 0, 4'hF, "por_stage0");
        push(r + 24, RD, 3'b111, 1, 0, 4'hF, "por_ready");
        push(r + 30, RD, 3'b111, 1, 0, 4'hF, "por_sync_lat");
        push(r + 31, WP, 3'b000, 0, 0, 4'hF, "por_drop");
        push(r + 34, WP, 3'b000, 0, 0, 4'hF, "por_hold");
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, cyc, STATE, STAGE_RESET_N, SYS_READY, TIMEOUT_ERR,
                        DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == r + 28) FABRIC_POR_N = 1'b0;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_por_loss: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_ready_loss();
        int g = 0;
        exp_t e;
        apply_reset(1'b1, 4'hF, 4'hF);
        push(r + 24, RD, 3'b111, 1, 0, 4'hF, "loss_ready");
        push(r + 30, RD, 3'b111, 1, 0, 4'hE, "loss_synced");
`ifdef INIT_SEQ_LOSS_DETECT_EN
        push(r + 31, FT, 3'b000, 0, 1, 4'hE, "loss_fault");
        push(r + 35, FT, 3'b000, 0, 1, 4'hE, "loss_fault_hold");
`else
        push(r + 31, RD, 3'b111, 1, 0, 4'hE, "loss_ignored");
        push(r + 35, RD, 3'b111, 1, 0, 4'hE, "loss_ignored_hold");
`endif
        while (sb.size() != 0 && g < 300) begin
            step(); g++;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front(); n_run++;
                if (STATE !== e.st || STAGE_RESET_N !== e.stg ||
                    SYS_READY !== e.rdy || TIMEOUT_ERR !== e.terr ||
                    DONE_SYNC !== e.ds) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got st=%0d stg=%b rdy=%b terr=%b ds=%h want st=%0d stg=%b rdy=%b terr=%b ds=%h",
                        e.nm, cyc, STATE, STAGE_RESET_N, SYS_READY, TIMEOUT_ERR,
                        DONE_SYNC, e.st, e.stg, e.rdy, e.terr, e.ds);
                end
            end
            if (cyc == r + 28) DONE_IN = 4'hE;
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL test_ready_loss: %0d expectations not reached", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_normal(4'hF, 4'hF);
        test_normal(4'h7, 4'h7);
        test_timeout();
        test_stable_restart();
        test_timeout_hold();
        test_por_loss();
        test_ready_loss();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
